// File: rtl/tetris_pkg.sv
// Shared constants, state encoding and piece-footprint helpers for the tetris game core.
package tetris_pkg;

  localparam int COLS  = 10;
  localparam int ROWS  = 16;
  localparam int CELLS = 160;
  localparam logic [7:0] SPAWN_LOC = 8'd3;

  typedef enum logic [1:0] {
    ST_I   = 2'd0,
    ST_GEN = 2'd1,
    ST_ROT = 2'd2,
    ST_COL = 2'd3
  } state_t;

  function automatic logic [3:0] loc_col(input logic [7:0] loc);
    return 4'(loc % 8'd10);
  endfunction

  function automatic logic [3:0] loc_row(input logic [7:0] loc);
    return 4'(loc / 8'd10);
  endfunction

  // Odd orientations are vertical: cells stacked one row (10 cells) apart.
  function automatic logic [CELLS-1:0] piece_mask(input logic [7:0] loc,
                                                  input logic [1:0] orient);
    logic [CELLS-1:0] base;
    base = '0;
    if (orient[0]) begin
      base[0]  = 1'b1;
      base[10] = 1'b1;
      base[20] = 1'b1;
      base[30] = 1'b1;
    end else begin
      base[3:0] = 4'hF;
    end
    return base << loc;
  endfunction

endpackage

// File: rtl/tetris_row_clear.sv
// Full-row detection and removal of the lowest full row, shifting the rows above it down by one.
module tetris_row_clear
  import tetris_pkg::*;
(
  input  logic [CELLS-1:0] board,
  output logic             any_full,
  output logic [CELLS-1:0] board_next
);

  logic [3:0] low_row;

  always_comb begin
    any_full = 1'b0;
    low_row  = 4'd0;
    // Later (lower) rows overwrite earlier hits, leaving the bottom-most full row.
    for (int r = 0; r < ROWS; r++) begin
      if (&board[r*COLS +: COLS]) begin
        any_full = 1'b1;
        low_row  = 4'(r);
      end
    end
  end

  always_comb begin
    board_next = board;
    if (any_full) begin
      board_next[COLS-1:0] = '0;
      for (int r = 1; r < ROWS; r++) begin
        if (r <= int'(low_row))
          board_next[r*COLS +: COLS] = board[(r-1)*COLS +: COLS];
      end
    end
  end

endmodule

// File: rtl/tetris.sv
// Falling I-piece game core: spawn, move, lock, row clear and score.
// Optional automatic drop enabled by defining TETRIS_GRAVITY_EN.
//   state | meaning
//   I     | idle / game over, waiting for Start or Ack
//   Gen   | spawn new piece at SPAWN_LOC, game over on collision
//   Rot   | piece active, Left/Right/Down applied each cycle
//   Col   | lock piece, then clear full rows one per cycle
module tetris
  import tetris_pkg::*;
#(
  parameter int unsigned DROP_TICKS = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic             Left,
  input  logic             Right,
  input  logic             Down,
  output logic             q_I,
  output logic             q_Gen,
  output logic             q_Rot,
  output logic             q_Col,
  output logic [CELLS-1:0] blocks,
  output logic [7:0]       score,
  output logic [1:0]       orientation,
  output logic [7:0]       location
);

  state_t           state;
  logic [CELLS-1:0] board;
  logic             lock_done;
  logic             any_full;
  logic [CELLS-1:0] board_cleared;
  logic             grav_drop;

  logic             horiz;
  logic [3:0]       cur_col;
  logic [3:0]       right_col;
  logic [3:0]       bot_row;
  logic [7:0]       loc_h;
  logic             down_req;
  logic             down_ok;

  tetris_row_clear u_row_clear (
    .board      (board),
    .any_full   (any_full),
    .board_next (board_cleared)
  );

`ifdef TETRIS_GRAVITY_EN
  logic [15:0] tick_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      tick_cnt <= 16'(DROP_TICKS - 1);
    else if (state != ST_ROT || tick_cnt == 16'd0)
      tick_cnt <= 16'(DROP_TICKS - 1);
    else
      tick_cnt <= tick_cnt - 16'd1;
  end

  assign grav_drop = (state == ST_ROT) && (tick_cnt == 16'd0);
`else
  // No automatic drop; the parameter stays on the interface so both builds share one port/param list.
  assign grav_drop = 1'b0 & (DROP_TICKS == 0);
`endif

  always_comb begin
    horiz     = ~orientation[0];
    cur_col   = loc_col(location);
    right_col = cur_col + (horiz ? 4'd3 : 4'd0);
    loc_h     = location;
    if (Left && !Right && cur_col != 4'd0 &&
        (piece_mask(location - 8'd1, orientation) & board) == '0)
      loc_h = location - 8'd1;
    else if (Right && !Left && right_col < 4'd9 &&
             (piece_mask(location + 8'd1, orientation) & board) == '0)
      loc_h = location + 8'd1;
    bot_row  = loc_row(loc_h) + (horiz ? 4'd0 : 4'd3);
    down_req = Down | grav_drop;
    down_ok  = (bot_row < 4'd15) &&
               ((piece_mask(loc_h + 8'd10, orientation) & board) == '0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_I;
      board       <= '0;
      score       <= 8'd0;
      orientation <= 2'd0;
      location    <= SPAWN_LOC;
      lock_done   <= 1'b0;
    end else begin
      case (state)
        ST_I: begin
          if (Start) begin
            board       <= '0;
            score       <= 8'd0;
            orientation <= 2'd0;
            state       <= ST_GEN;
          end else if (Ack) begin
            board <= '0;
            score <= 8'd0;
          end
        end
        ST_GEN: begin
          location <= SPAWN_LOC;
          if ((piece_mask(SPAWN_LOC, orientation) & board) != '0)
            state <= ST_I;
          else
            state <= ST_ROT;
        end
        ST_ROT: begin
          if (down_req && down_ok) begin
            location <= loc_h + 8'd10;
          end else begin
            location <= loc_h;
            if (down_req) begin
              lock_done <= 1'b0;
              state     <= ST_COL;
            end
          end
        end
        ST_COL: begin
          if (!lock_done) begin
            board     <= board | piece_mask(location, orientation);
            lock_done <= 1'b1;
          end else if (any_full) begin
            board <= board_cleared;
            if (score != 8'hFF)
              score <= score + 8'd1;
          end else begin
            orientation <= orientation + 2'd1;
            state       <= ST_GEN;
          end
        end
        default: state <= ST_I;
      endcase
    end
  end

  assign q_I    = (state == ST_I);
  assign q_Gen  = (state == ST_GEN);
  assign q_Rot  = (state == ST_ROT);
  assign q_Col  = (state == ST_COL);
  assign blocks = board | ((state == ST_ROT) ? piece_mask(location, orientation) : '0);

endmodule

// File: tb/tb_tetris.sv
// Directed self-checking bench for the tetris core; expected move/lock locations go through a scoreboard queue.
module tb_tetris;

  logic         Clk_tb = 1'b0;
  logic         Reset  = 1'b0;
  logic         Start  = 1'b0;
  logic         Ack    = 1'b0;
  logic         Left   = 1'b0;
  logic         Right  = 1'b0;
  logic         Down   = 1'b0;
  logic         q_I, q_Gen, q_Rot, q_Col;
  logic [159:0] blocks;
  logic [7:0]   score;
  logic [1:0]   orientation;
  logic [7:0]   location;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  logic [159:0] e;

  localparam logic [3:0] F_I = 4'b1000, F_GEN = 4'b0100, F_ROT = 4'b0010, F_COL = 4'b0001;

  tetris dut (
    .Clk         (Clk_tb),
    .Reset       (Reset),
    .Start       (Start),
    .Ack         (Ack),
    .Left        (Left),
    .Right       (Right),
    .Down        (Down),
    .q_I         (q_I),
    .q_Gen       (q_Gen),
    .q_Rot       (q_Rot),
    .q_Col       (q_Col),
    .blocks      (blocks),
    .score       (score),
    .orientation (orientation),
    .location    (location)
  );

  always #5 Clk_tb = ~Clk_tb;

  task automatic step();
    @(posedge Clk_tb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] exp);
    chk(tag, {156'd0, q_I, q_Gen, q_Rot, q_Col}, {156'd0, exp});
  endtask

  task automatic mv(input logic l, input logic r, input logic d, input int exp_loc);
    Left  = l;
    Right = r;
    Down  = d;
    exp_q.push_back(exp_loc);
    step();
    Left  = 1'b0;
    Right = 1'b0;
    Down  = 1'b0;
    chk("move_loc", location, exp_q.pop_front());
  endtask

  // Hold Down until the piece locks; afterwards the core sits in Gen (or I).
  task automatic drop(input int exp_lock);
    int n;
    n = 0;
    Down = 1'b1;
    exp_q.push_back(exp_lock);
    while (!q_Col && n < 64) begin
      step();
      n++;
    end
    Down = 1'b0;
    chk_state("reach_col", F_COL);
    chk("lock_loc", location, exp_q.pop_front());
    n = 0;
    while (q_Col && n < 32) begin
      step();
      n++;
    end
    chk("leave_col", {159'd0, q_Col}, 160'd0);
  endtask

  task automatic to_rot();
    step();
    chk_state("gen_to_rot", F_ROT);
  endtask

  initial begin
    #2 Reset = 1'b1;
    #2;
    chk_state("rst_flags", F_I);
    chk("rst_blocks", blocks, 160'd0);
    chk("rst_score", score, 160'd0);
    chk("rst_orient", orientation, 160'd0);
    chk("rst_loc", location, 160'd3);
    step();
    Reset = 1'b0;

    Start = 1'b1;
    step();
    Start = 1'b0;
    chk_state("start_gen", F_GEN);
    step();
    chk_state("gen_rot", F_ROT);
    chk("spawn_loc", location, 160'd3);
    chk("spawn_orient", orientation, 160'd0);
    chk("spawn_blocks", blocks, 160'h78);
    chk("spawn_score", score, 160'd0);

    mv(1, 0, 0, 2); mv(1, 0, 0, 1);
    mv(0, 1, 0, 2); mv(0, 1, 0, 3); mv(0, 1, 0, 4);
    mv(1, 0, 0, 3);
    mv(1, 0, 0, 2); mv(1, 0, 0, 1); mv(1, 0, 0, 0); mv(1, 0, 0, 0); mv(1, 0, 0, 0);
    mv(1, 1, 0, 0);
    for (int i = 1; i <= 8; i++) mv(0, 1, 0, (i < 6) ? i : 6);
    mv(1, 0, 0, 5); mv(1, 0, 0, 4); mv(1, 0, 0, 3);
    for (int k = 1; k <= 15; k++) mv(0, 0, 1, 3 + 10 * k);

    Down = 1'b1;
    step();
    Down = 1'b0;
    chk_state("bottom_col", F_COL);
    chk("bottom_loc", location, 160'd153);
    step();
    e = '0;
    e[156:153] = 4'hF;
    chk("bottom_lock", blocks, e);
    step();
    chk_state("after_lock_gen", F_GEN);
    chk("orient_inc", orientation, 160'd1);
    to_rot();
    chk("vert_spawn_loc", location, 160'd3);
    e[3] = 1'b1; e[13] = 1'b1; e[23] = 1'b1; e[33] = 1'b1;
    chk("vert_blocks", blocks, e);

    // Fresh game: build a full bottom row from four pieces.
    Reset = 1'b1;
    #1;
    chk_state("async_rst", F_I);
    chk("async_rst_blocks", blocks, 160'd0);
    Reset = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    to_rot();
    mv(1, 0, 0, 2); mv(1, 0, 0, 1); mv(1, 0, 0, 0);
    drop(150);
    to_rot();
    mv(0, 1, 0, 4);
    drop(124);
    to_rot();
    mv(0, 1, 0, 4); mv(0, 1, 0, 5); mv(0, 1, 0, 6);
    drop(156);
    to_rot();
    mv(0, 1, 0, 4); mv(0, 1, 0, 5);
    drop(125);
    chk_state("clear_gen", F_GEN);
    chk("clear_score", score, 160'd1);
    chk("clear_orient", orientation, 160'd0);
    e = '0;
    e[134] = 1'b1; e[135] = 1'b1; e[144] = 1'b1; e[145] = 1'b1; e[154] = 1'b1; e[155] = 1'b1;
    chk("clear_blocks", blocks, e);
    to_rot();

    // Stack at the spawn column until the next spawn collides.
    drop(123); to_rot();
    drop(83);  to_rot();
    drop(73);  to_rot();
    drop(33);  to_rot();
    drop(23);
    chk_state("last_gen", F_GEN);
    step();
    chk_state("game_over", F_I);
    chk("over_score", score, 160'd1);
    e[126:123] = 4'hF;
    e[83] = 1'b1; e[93] = 1'b1; e[103] = 1'b1; e[113] = 1'b1;
    e[76:73] = 4'hF;
    e[33] = 1'b1; e[43] = 1'b1; e[53] = 1'b1; e[63] = 1'b1;
    e[26:23] = 4'hF;
    chk("over_blocks", blocks, e);
    step();
    chk_state("idle_hold", F_I);

    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk_state("ack_idle", F_I);
    chk("ack_blocks", blocks, 160'd0);
    chk("ack_score", score, 160'd0);

    Start = 1'b1;
    Ack   = 1'b1;
    step();
    Start = 1'b0;
    Ack   = 1'b0;
    chk_state("start_prio", F_GEN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
